// File: rtl/display_pkg.sv
// Shared display constants: XVGA 1024x768@60 raster timing and
// the screen geometry the display writer uses for x/y conversion.
package display_pkg;

  localparam int XVGA_H_ACTIVE = 1024;
  localparam int XVGA_H_FP     = 24;
  localparam int XVGA_H_SYNC   = 136;
  localparam int XVGA_H_BP     = 160;
  localparam int XVGA_H_TOTAL  = XVGA_H_ACTIVE + XVGA_H_FP
                               + XVGA_H_SYNC + XVGA_H_BP;

  localparam int XVGA_V_ACTIVE = 768;
  localparam int XVGA_V_FP     = 3;
  localparam int XVGA_V_SYNC   = 6;
  localparam int XVGA_V_BP     = 29;
  localparam int XVGA_V_TOTAL  = XVGA_V_ACTIVE + XVGA_V_FP
                               + XVGA_V_SYNC + XVGA_V_BP;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;
  localparam int SCREEN_CX     = SCREEN_WIDTH / 2;
  localparam int SCREEN_CY     = SCREEN_HEIGHT / 2;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping counter plus registered sync/active
// decode that always describes the count presented alongside it.
module timing_axis
  import display_pkg::*;
#(
  parameter int ACTIVE = XVGA_H_ACTIVE,
  parameter int FP     = XVGA_H_FP,
  parameter int SYNC   = XVGA_H_SYNC,
  parameter int BP     = XVGA_H_BP,
  parameter int W      = HCOUNT_W
) (
  input  logic         vclock,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         sync_n,
  output logic         active,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_q, count_d;
  logic         sync_n_q, sync_n_d;
  logic         active_q, active_d;

  // Terminal compare happens before increment so count stays < TOTAL.
  always_comb begin
    count_d = count_q;
    if (advance) begin
      if (count_q == LAST) count_d = '0;
      else                 count_d = count_q + 1'b1;
    end
    sync_n_d = !((count_d >= SYNC_LO) && (count_d < SYNC_HI));
    active_d = (count_d < ACT_END);
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
      active_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
      active_q <= active_d;
    end
  end

  assign wrap   = advance && (count_q == LAST);
  assign count  = count_q;
  assign sync_n = sync_n_q;
  assign active = active_q;

endmodule

// File: rtl/xvga_timing.sv
// XVGA raster timing generator with frame-boundary strobes and a
// completed-frame counter for synchronous latching downstream.
module xvga_timing
  import display_pkg::*;
#(
  parameter int H_ACTIVE = XVGA_H_ACTIVE,
  parameter int H_FP     = XVGA_H_FP,
  parameter int H_SYNC   = XVGA_H_SYNC,
  parameter int H_BP     = XVGA_H_BP,
  parameter int V_ACTIVE = XVGA_V_ACTIVE,
  parameter int V_FP     = XVGA_V_FP,
  parameter int V_SYNC   = XVGA_V_SYNC,
  parameter int V_BP     = XVGA_V_BP
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        enable,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam logic [9:0] V_LAST_ACT = 10'(V_ACTIVE - 1);

  logic h_wrap, v_wrap, v_adv;
  logic h_act, v_act;
  logic frame_start_q, frame_start_d;
  logic vblank_start_q, vblank_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  assign v_adv = h_wrap & enable;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (11)
  ) u_h (
    .vclock  (vclock),
    .reset   (reset),
    .advance (enable),
    .count   (hcount),
    .sync_n  (hsync),
    .active  (h_act),
    .wrap    (h_wrap)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (10)
  ) u_v (
    .vclock  (vclock),
    .reset   (reset),
    .advance (v_adv),
    .count   (vcount),
    .sync_n  (vsync),
    .active  (v_act),
    .wrap    (v_wrap)
  );

  // Strobes only fire when (0,0)/(0,V_ACTIVE) is entered by advancing.
  always_comb begin
    frame_start_d  = h_wrap & v_wrap;
    vblank_start_d = h_wrap & (vcount == V_LAST_ACT);
    frame_count_d  = frame_count_q;
    if (frame_start_d) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  // Gating by enable kills a pulse at once when the raster freezes.
  assign frame_start  = frame_start_q & enable;
  assign vblank_start = vblank_start_q & enable;
  assign blank        = ~(h_act & v_act);
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_xvga_timing.sv
// Bench: small-raster and default-XVGA instances checked every cycle
// against a linear pixel-position model.
module tb_xvga_timing;

  localparam int HA [2] = '{40, 1024};
  localparam int HF [2] = '{4, 24};
  localparam int HS [2] = '{8, 136};
  localparam int HB [2] = '{12, 160};
  localparam int VA [2] = '{20, 768};
  localparam int VF [2] = '{3, 3};
  localparam int VS [2] = '{6, 6};
  localparam int VB [2] = '{7, 29};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  logic [10:0] hc   [2];
  logic [9:0]  vc   [2];
  logic        hs   [2];
  logic        vs   [2];
  logic        bl   [2];
  logic        fs   [2];
  logic        vbs  [2];
  logic [15:0] fcnt [2];

  int          p   [2];
  logic [15:0] fc  [2];
  bit          arm [2];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  xvga_timing #(
    .H_ACTIVE (40), .H_FP (4), .H_SYNC (8), .H_BP (12),
    .V_ACTIVE (20), .V_FP (3), .V_SYNC (6), .V_BP (7)
  ) dut_s (
    .vclock       (clk),
    .reset        (rst),
    .enable       (en),
    .hcount       (hc[0]),
    .vcount       (vc[0]),
    .hsync        (hs[0]),
    .vsync        (vs[0]),
    .blank        (bl[0]),
    .frame_start  (fs[0]),
    .vblank_start (vbs[0]),
    .frame_count  (fcnt[0])
  );

  xvga_timing dut_x (
    .vclock       (clk),
    .reset        (rst),
    .enable       (en),
    .hcount       (hc[1]),
    .vcount       (vc[1]),
    .hsync        (hs[1]),
    .vsync        (vs[1]),
    .blank        (bl[1]),
    .frame_start  (fs[1]),
    .vblank_start (vbs[1]),
    .frame_count  (fcnt[1])
  );

  function automatic int ht(int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int ft(int i);
    return ht(i) * (VA[i] + VF[i] + VS[i] + VB[i]);
  endfunction

  task automatic chk(string tag, int i, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s dut%0d got %0d expected %0d", tag, i, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      p[i] = 0;
      fc[i] = '0;
      arm[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        p[i] = 0;
        fc[i] = '0;
        arm[i] = 1'b0;
      end else if (en) begin
        p[i] = (p[i] + 1) % ft(i);
        arm[i] = 1'b1;
        if (p[i] == 0) fc[i] = fc[i] + 16'd1;
      end else begin
        arm[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int h, v;
      bit ehs, evs, ebl, efs, evb;
      h = p[i] % ht(i);
      v = p[i] / ht(i);
      ehs = !(h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]);
      evs = !(v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]);
      ebl = (h >= HA[i]) || (v >= VA[i]);
      efs = arm[i] && en && (p[i] == 0);
      evb = arm[i] && en && (p[i] == VA[i] * ht(i));
      chk("hcount", i, 32'(hc[i]), 32'(h));
      chk("vcount", i, 32'(vc[i]), 32'(v));
      chk("hsync", i, 32'(hs[i]), 32'(ehs));
      chk("vsync", i, 32'(vs[i]), 32'(evs));
      chk("blank", i, 32'(bl[i]), 32'(ebl));
      chk("frame_start", i, 32'(fs[i]), 32'(efs));
      chk("vblank_start", i, 32'(vbs[i]), 32'(evb));
      chk("frame_count", i, 32'(fcnt[i]), 32'(fc[i]));
    end
  endtask

  // One clock: edge, model update, then drive next enable and check.
  task automatic cycle(input bit next_en);
    @(posedge clk);
    model_edge();
    #1;
    en = next_en;
    #1;
    check_all();
  endtask

  task automatic wait_pos(input int target);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 5000 && !hit; k++) begin
      cycle(1'b1);
      if (p[0] == target) hit = 1'b1;
    end
    chk("reach_pos", 0, 32'(hit), 32'd1);
  endtask

  initial begin
    int cnt;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_all();
    cycle(1'b0);
    cycle(1'b0);

    // First line of the default raster from reset release
    rst = 1'b0;
    en  = 1'b1;
    #1;
    check_all();
    repeat (ht(1)) cycle(1'b1);
    chk("line_wrap_h", 1, 32'(hc[1]), 32'd0);
    chk("line_wrap_v", 1, 32'(vc[1]), 32'd1);

    // Two full small frames: one frame_start per frame
    cnt = 0;
    repeat (2 * ft(0)) begin
      cycle(1'b1);
      if (fs[0] === 1'b1) cnt++;
    end
    chk("fs_per_2frames", 0, 32'(cnt), 32'd2);

    // Freeze mid-line in the active region
    wait_pos(10 * ht(0) + 30);
    en = 1'b0;
    #1;
    check_all();
    repeat (1000) cycle(1'b0);
    chk("hold_h", 0, 32'(hc[0]), 32'd30);
    chk("hold_blank", 0, 32'(bl[0]), 32'd0);
    cycle(1'b1);
    cycle(1'b1);
    chk("resume_h", 0, 32'(hc[0]), 32'd31);
    chk("resume_v", 0, 32'(vc[0]), 32'd10);

    // Drop enable inside the vblank_start cycle
    wait_pos(VA[0] * ht(0));
    chk("vbs_seen", 0, 32'(vbs[0]), 32'd1);
    en = 1'b0;
    #1;
    chk("vbs_killed", 0, 32'(vbs[0]), 32'd0);
    check_all();
    repeat (5) cycle(1'b0);
    cycle(1'b1);
    chk("vbs_no_reissue", 0, 32'(vbs[0]), 32'd0);
    cycle(1'b1);

    // Asynchronous reset inside hsync and vsync
    wait_pos(25 * ht(0) + 46);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_fc", 0, 32'(fcnt[0]), 32'd0);
    repeat (3) cycle(1'b1);
    rst = 1'b0;
    repeat (100) cycle(1'b1);
    chk("rst_no_fs", 0, 32'(fs[0]), 32'd0);

    // Random enable pattern with occasional resets
    for (int k = 0; k < 6000; k++) begin
      cycle($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1999) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle(1'b1);
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
